vend_ctrl: RTL

Parametrised vending-machine controller: the next-generation of the team's product-select/pay/dispense FSM, generalised to N products with per-product stock, quantity selection, coin accumulation, timeouts, and ready/valid dispense and change channels. It sits between the keypad decoder (already-debounced one-cycle pulses) and the dispense/coin-return actuators. The price table is a port, so firmware or switches can reprice products without re-synthesis.

---
 rtl/vend_pkg.sv | 34 +++
 rtl/vend_stock.sv | 48 ++++
 rtl/vend_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared state encoding, coin codes and width helpers for the vending controller.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_CONFIRM  = 3'd2,
    ST_PAY      = 3'd3,
    ST_DISPENSE = 3'd4,
    ST_CHANGE   = 3'd5
  } vend_state_e;

  localparam logic [1:0] COIN_2   = 2'b00;
  localparam logic [1:0] COIN_5   = 2'b01;
  localparam logic [1:0] COIN_10  = 2'b10;
  localparam logic [1:0] COIN_BAD = 2'b11;

  localparam int COIN_VAL_W = 4;

  function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_2:  return 4'd2;
      COIN_5:  return 4'd5;
      COIN_10: return 4'd10;
      default: return 4'd0;
    endcase
  endfunction

  // Room for the largest price*qty plus one more coin before payment completes.
  function automatic int amt_width(input int price_w, input int qty_w);
    return price_w + qty_w + 1;
  endfunction

endpackage

// File: rtl/vend_stock.sv
// Per-product stock counters with availability lookup, single-unit decrement and restock.
module vend_stock
  import vend_pkg::*;
#(
  parameter  int N_PROD     = 8,
  parameter  int STOCK_W    = 4,
  parameter  int QTY_W      = 3,
  parameter  int INIT_STOCK = 5,
  localparam int ID_W       = $clog2(N_PROD)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ID_W-1:0]  chk_id,
  input  logic [QTY_W-1:0] chk_qty,
  output logic             avail,
  input  logic             dec_en,
  input  logic [ID_W-1:0]  dec_id,
  input  logic             restock_en,
  input  logic [ID_W-1:0]  restock_id
);

  logic [STOCK_W-1:0] stock [N_PROD];

  // NOTE: the stock array is a real state register with a reset value, so it is
  // reset like any other flop; a RAM-style array would be left unreset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_PROD; i++) stock[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      for (int i = 0; i < N_PROD; i++) begin
        if (restock_en && restock_id == ID_W'(i)) stock[i] <= STOCK_W'(INIT_STOCK);
        else if (dec_en && dec_id == ID_W'(i))    stock[i] <= stock[i] - STOCK_W'(1);
      end
    end
  end

  // NOTE: combinational outputs get a default before any conditional update so
  // no path leaves them unassigned (which would infer a latch).
  always_comb begin
    avail = 1'b0;
    for (int i = 0; i < N_PROD; i++) begin
      if (chk_id == ID_W'(i)) avail = (32'(stock[i]) >= 32'(chk_qty));
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: select/confirm/pay/dispense/change FSM with per-product stock.
// Define VEND_CHANGE_EN to accept overpayment and return the excess as change.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter  int N_PROD      = 8,
  parameter  int PRICE_W     = 8,
  parameter  int QTY_W       = 3,
  parameter  int STOCK_W     = 4,
  parameter  int INIT_STOCK  = 5,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int ID_W        = $clog2(N_PROD),
  localparam int AMT_W       = amt_width(PRICE_W, QTY_W)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      sel_valid,
  input  logic [ID_W-1:0]           sel_id,
  input  logic [QTY_W-1:0]          qty,
  input  logic                      confirm,
  input  logic                      cancel,
  input  logic                      coin_valid,
  input  logic [1:0]                coin_sel,
  input  logic                      restock,
  input  logic [N_PROD*PRICE_W-1:0] price_tbl,
  output logic [PRICE_W-1:0]        view_price,
  output logic [QTY_W-1:0]          view_qty,
  output logic [AMT_W-1:0]          total_due,
  output logic [AMT_W-1:0]          credit,
  output logic                      dispense_valid,
  output logic [ID_W-1:0]           dispense_id,
  input  logic                      dispense_ready,
  output logic                      change_valid,
  output logic [AMT_W-1:0]          change_amt,
  input  logic                      change_ready,
  output logic                      coin_reject,
  output logic                      err_soldout,
  output logic                      err_timeout,
  output logic [2:0]                state_o
);

  localparam int              TMO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  vend_state_e        state, state_d;
  logic [PRICE_W-1:0] price_sel, view_price_d;
  logic [QTY_W-1:0]   view_qty_d, disp_cnt, disp_cnt_d;
  logic [ID_W-1:0]    dispense_id_d;
  logic [AMT_W-1:0]   total_due_d, credit_d, change_amt_d, credit_sum;
  logic [TMO_W-1:0]   tmo_cnt, tmo_d;
  logic               avail, sel_ok, timed, abort;
  logic               sel_accept, coin_accept, dec_en, restock_en;
  logic               coin_reject_d, err_soldout_d, err_timeout_d;

  vend_stock #(
    .N_PROD     (N_PROD),
    .STOCK_W    (STOCK_W),
    .QTY_W      (QTY_W),
    .INIT_STOCK (INIT_STOCK)
  ) u_stock (
    .clk        (clk),
    .reset      (reset),
    .chk_id     (sel_id),
    .chk_qty    (qty),
    .avail      (avail),
    .dec_en     (dec_en),
    .dec_id     (dispense_id),
    .restock_en (restock_en),
    .restock_id (sel_id)
  );

  assign price_sel  = price_tbl[32'(sel_id)*PRICE_W +: PRICE_W];
  assign sel_ok     = (qty != '0) && (int'(sel_id) < N_PROD) && avail;
  assign credit_sum = credit + AMT_W'(coin_value(coin_sel));
  assign timed      = (state == ST_SELECT) || (state == ST_CONFIRM) || (state == ST_PAY);
  assign abort      = timed && (cancel || tmo_cnt == TMO_LAST);
  assign state_o    = state;

  always_comb begin
    state_d       = state;
    view_price_d  = view_price;
    view_qty_d    = view_qty;
    total_due_d   = total_due;
    credit_d      = credit;
    change_amt_d  = change_amt;
    dispense_id_d = dispense_id;
    disp_cnt_d    = '0;
    sel_accept    = 1'b0;
    coin_accept   = 1'b0;
    dec_en        = 1'b0;
    restock_en    = 1'b0;
    err_soldout_d = 1'b0;
    err_timeout_d = 1'b0;

    case (state)
      ST_IDLE: begin
        restock_en = restock;
        if (start) state_d = ST_SELECT;
      end

      ST_SELECT, ST_CONFIRM, ST_PAY: begin
        if (abort) begin
          err_timeout_d = !cancel;
          if (state == ST_PAY && credit != '0) begin
            state_d      = ST_CHANGE;
            change_amt_d = credit;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (state == ST_CONFIRM && confirm) begin
          credit_d = '0;
          state_d  = (total_due == '0) ? ST_DISPENSE : ST_PAY;
        end else if (state != ST_PAY && sel_valid) begin
          if (sel_ok) begin
            sel_accept    = 1'b1;
            dispense_id_d = sel_id;
            view_qty_d    = qty;
            view_price_d  = price_sel;
            total_due_d   = AMT_W'(price_sel) * AMT_W'(qty);
            state_d       = ST_CONFIRM;
          end else begin
            err_soldout_d = 1'b1;
          end
        end else if (state == ST_PAY && coin_valid && coin_sel != COIN_BAD) begin
`ifdef VEND_CHANGE_EN
          coin_accept = 1'b1;
`else
          // Exact payment only: a coin that would overshoot is handed straight back.
          coin_accept = (credit_sum <= total_due);
`endif
          if (coin_accept) begin
            credit_d = credit_sum;
            if (credit_sum >= total_due) state_d = ST_DISPENSE;
          end
        end
      end

      ST_DISPENSE: begin
        disp_cnt_d = disp_cnt;
        if (dispense_ready) begin
          dec_en     = 1'b1;
          disp_cnt_d = disp_cnt + QTY_W'(1);
          if (disp_cnt == view_qty - QTY_W'(1)) begin
            if (credit > total_due) begin
              state_d      = ST_CHANGE;
              change_amt_d = credit - total_due;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end

      ST_CHANGE: if (change_ready) state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    // Money is never carried across a return to IDLE.
    if (state_d == ST_IDLE) begin
      credit_d     = '0;
      change_amt_d = '0;
    end

    coin_reject_d = coin_valid && !coin_accept;
    // Idle timer restarts on any state change or accepted selection/coin.
    if (timed && state_d == state && !(sel_accept || coin_accept)) tmo_d = tmo_cnt + TMO_W'(1);
    else                                                          tmo_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      view_price     <= '0;
      view_qty       <= '0;
      total_due      <= '0;
      credit         <= '0;
      change_amt     <= '0;
      dispense_id    <= '0;
      disp_cnt       <= '0;
      tmo_cnt        <= '0;
      dispense_valid <= 1'b0;
      change_valid   <= 1'b0;
      coin_reject    <= 1'b0;
      err_soldout    <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      state          <= state_d;
      view_price     <= view_price_d;
      view_qty       <= view_qty_d;
      total_due      <= total_due_d;
      credit         <= credit_d;
      change_amt     <= change_amt_d;
      dispense_id    <= dispense_id_d;
      disp_cnt       <= disp_cnt_d;
      tmo_cnt        <= tmo_d;
      dispense_valid <= (state_d == ST_DISPENSE);
      change_valid   <= (state_d == ST_CHANGE);
      coin_reject    <= coin_reject_d;
      err_soldout    <= err_soldout_d;
      err_timeout    <= err_timeout_d;
    end
  end

endmodule
